// File: rtl/demux_stream_1n.sv
// Registered 1-to-N stream demux with a one-entry holding register per channel; 1-cycle latency.
// in_ready drops only when the targeted channel (or, for broadcast, any channel) is full and not draining.
module demux_stream_1n #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WIDTH-1:0]                v,
  input  logic [SEL_W-1:0]                s,
  input  logic                            bcast,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [(2**SEL_W)*WIDTH-1:0]     a,
  output logic [(2**SEL_W)-1:0]           a_valid,
  input  logic [(2**SEL_W)-1:0]           a_ready,
  output logic [15:0]                     drop_cnt
);

  localparam int N = 2**SEL_W;

  logic [N-1:0]            vld_q, vld_d;
  logic [N-1:0][WIDTH-1:0] dat_q, dat_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;
  logic [N-1:0]            free;
  logic                    accept;

  always_comb begin
    free       = ~vld_q | a_ready;
    in_ready   = bcast ? (&free) : free[s];
    accept     = in_valid && in_ready;
    vld_d      = vld_q;
    dat_d      = dat_q;
    drop_cnt_d = drop_cnt_q;

    // A load wins over a drain so a channel can refill in the cycle it empties.
    for (int k = 0; k < N; k++) begin
      if (accept && (bcast || (s == SEL_W'(k)))) begin
        vld_d[k] = 1'b1;
        dat_d[k] = v;
      end else if (a_ready[k]) begin
        vld_d[k] = 1'b0;
        dat_d[k] = '0;
      end
    end

    if (in_valid && !in_ready && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      dat_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      vld_q      <= vld_d;
      dat_q      <= dat_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    a = '0;
    for (int k = 0; k < N; k++) begin
      a[k*WIDTH +: WIDTH] = vld_q[k] ? dat_q[k] : '0;
    end
  end

  assign a_valid  = vld_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream_1n.sv
// Bench for demux_stream_1n: directed scenarios plus a random run against a queue-based channel model.
module tb_demux_stream_1n;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  v;
  logic [3:0]   s;
  logic         bcast;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] a;
  logic [15:0]  a_valid;
  logic [15:0]  a_ready;
  logic [15:0]  drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: each channel is a queue holding at most one word; drop count as a plain integer.
  logic [15:0] chq [0:15][$];
  int          m_drop;

  always #5 clk = ~clk;

  demux_stream_1n #(.WIDTH(16), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .v(v), .s(s), .bcast(bcast),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .a_valid(a_valid),
    .a_ready(a_ready), .drop_cnt(drop_cnt)
  );

  function automatic logic m_free(int k);
    return (chq[k].size() == 0) || a_ready[k];
  endfunction

  function automatic logic m_rdy();
    logic r;
    if (!bcast) return m_free(int'(s));
    r = 1'b1;
    for (int k = 0; k < 16; k++) r = r & m_free(k);
    return r;
  endfunction

  function automatic logic [15:0] m_vld();
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = (chq[k].size() != 0);
    return r;
  endfunction

  function automatic logic [255:0] m_a();
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) if (chq[k].size() != 0) r[k*16 +: 16] = chq[k][0];
    return r;
  endfunction

  function automatic void m_clear();
    for (int k = 0; k < 16; k++) chq[k].delete();
    m_drop = 0;
  endfunction

  // Advance model and DUT by one clock; inputs must already be stable.
  task automatic tick();
    logic acc;
    acc = in_valid && m_rdy();
    if (in_valid && !acc && m_drop < 65535) m_drop++;
    for (int k = 0; k < 16; k++) begin
      if (a_ready[k] && chq[k].size() != 0) void'(chq[k].pop_front());
      if (acc && (bcast || s == 4'(k))) chq[k].push_back(v);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    v = '0; s = '0; bcast = 1'b0; in_valid = 1'b0; a_ready = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_clear();
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_chk++; if (a_valid !== 16'h0) begin n_fail++; $display("FAIL reset_a_valid got %h want 0000", a_valid); end
    n_chk++; if (a !== 256'h0) begin n_fail++; $display("FAIL reset_a got %h want 0", a); end
    n_chk++; if (drop_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_drop got %h want 0000", drop_cnt); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    bcast = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_bcast got %b want 1", in_ready); end
    bcast = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
  endtask

  task automatic test_unicast_sweep();
    do_reset();
    v = 16'h000F; in_valid = 1'b1; a_ready = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) in_valid = 1'b0;
      s = 4'(i);
      #1;
      if (i < 16) begin
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_in_ready s=%0d got %b want 1", i, in_ready); end
      end
      if (i > 0) begin
        n_chk++; if (a_valid !== (16'h1 << (i-1))) begin n_fail++; $display("FAIL sweep_a_valid s=%0d got %h want %h", i-1, a_valid, 16'h1 << (i-1)); end
        n_chk++; if (a !== m_a() || a[(i-1)*16 +: 16] !== 16'h000F) begin n_fail++; $display("FAIL sweep_a s=%0d got %h want %h", i-1, a, m_a()); end
      end
      n_chk++; if (drop_cnt !== 16'h0) begin n_fail++; $display("FAIL sweep_drop got %h want 0000", drop_cnt); end
      tick();
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    a_ready = ~16'h0008; s = 4'd3; v = 16'hA5A5; in_valid = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_first_ready got %b want 1", in_ready); end
    tick();
    v = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cyc=%0d got %b want 0", i, in_ready); end
      n_chk++; if (a[3*16 +: 16] !== 16'hA5A5 || a_valid[3] !== 1'b1) begin n_fail++; $display("FAIL stall_hold cyc=%0d got %h/%b want a5a5/1", i, a[3*16 +: 16], a_valid[3]); end
      tick();
    end
    #1;
    n_chk++; if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL stall_drop got %0d want 4", drop_cnt); end
    a_ready = 16'hFFFF;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    n_chk++; if (a[3*16 +: 16] !== 16'h1234 || a_valid !== 16'h0008) begin n_fail++; $display("FAIL stall_refill got %h/%h want 1234/0008", a[3*16 +: 16], a_valid); end
    n_chk++; if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL stall_drop_after got %0d want 4", drop_cnt); end
    tick();
  endtask

  task automatic test_independence();
    do_reset();
    a_ready = ~16'h0008; s = 4'd3; v = 16'hA5A5; in_valid = 1'b1;
    tick();
    s = 4'd7; v = 16'hBEEF;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL indep_in_ready got %b want 1", in_ready); end
    a_ready = 16'h0000;
    tick();
    in_valid = 1'b0;
    #1;
    n_chk++; if (a[7*16 +: 16] !== 16'hBEEF || a[3*16 +: 16] !== 16'hA5A5 || a_valid !== 16'h0088) begin n_fail++; $display("FAIL indep_data got a7=%h a3=%h vld=%h want beef a5a5 0088", a[7*16 +: 16], a[3*16 +: 16], a_valid); end
  endtask

  task automatic test_broadcast();
    do_reset();
    bcast = 1'b1; v = 16'hFFFF; in_valid = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bcast_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0; bcast = 1'b0;
    #1;
    n_chk++; if (a_valid !== 16'hFFFF || a !== {16{16'hFFFF}}) begin n_fail++; $display("FAIL bcast_all got vld=%h a=%h", a_valid, a); end
    a_ready = 16'hFFFF;
    tick();
    a_ready = ~16'h0200; s = 4'd9; v = 16'h0909; in_valid = 1'b1;
    tick();
    bcast = 1'b1; v = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bcast_blocked_ready cyc=%0d got %b want 0", i, in_ready); end
      n_chk++; if (a_valid !== 16'h0200 || a[9*16 +: 16] !== 16'h0909) begin n_fail++; $display("FAIL bcast_partial cyc=%0d got vld=%h a9=%h want 0200 0909", i, a_valid, a[9*16 +: 16]); end
      tick();
    end
    a_ready = 16'hFFFF;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bcast_release_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0; bcast = 1'b0; a_ready = 16'h0000;
    #1;
    n_chk++; if (a_valid !== 16'hFFFF || a !== {16{16'hFFFF}}) begin n_fail++; $display("FAIL bcast_after_release got vld=%h a=%h", a_valid, a); end
    n_chk++; if (drop_cnt !== 16'd3) begin n_fail++; $display("FAIL bcast_drop got %0d want 3", drop_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    a_ready = 16'h0020; s = 4'd5;
    for (int i = 0; i < 4; i++) begin
      v = 16'(i + 1); in_valid = (i < 3);
      #1;
      if (i < 3) begin
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready word=%0d got %b want 1", i+1, in_ready); end
      end
      if (i > 0) begin
        n_chk++; if (a_valid[5] !== 1'b1 || a[5*16 +: 16] !== 16'(i)) begin n_fail++; $display("FAIL b2b_data got %b/%h want 1/%h", a_valid[5], a[5*16 +: 16], 16'(i)); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v        = 16'($urandom);
      s        = 4'($urandom_range(0, 15));
      bcast    = ($urandom_range(0, 7) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      a_ready  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
      #1;
      n_chk++;
      if ({in_ready, a_valid, drop_cnt, a} !== {m_rdy(), m_vld(), 16'(m_drop), m_a()}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got rdy=%b vld=%h drop=%h a=%h want rdy=%b vld=%h drop=%h a=%h",
                 i, in_ready, a_valid, drop_cnt, a, m_rdy(), m_vld(), 16'(m_drop), m_a());
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    s = 4'd2; v = 16'h1111; in_valid = 1'b1;
    tick();
    s = 4'd9; v = 16'h2222;
    tick();
    s = 4'd2; v = 16'h3333;
    tick();
    in_valid = 1'b0;
    #1;
    n_chk++; if (a_valid !== 16'h0204 || drop_cnt !== 16'd1) begin n_fail++; $display("FAIL areset_pre got vld=%h drop=%0d want 0204 1", a_valid, drop_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (a_valid !== 16'h0) begin n_fail++; $display("FAIL areset_a_valid got %h want 0000", a_valid); end
    n_chk++; if (a !== 256'h0) begin n_fail++; $display("FAIL areset_a got %h want 0", a); end
    n_chk++; if (drop_cnt !== 16'h0) begin n_fail++; $display("FAIL areset_drop got %h want 0000", drop_cnt); end
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    m_clear();
    test_reset();
    test_unicast_sweep();
    test_stall_hold();
    test_independence();
    test_broadcast();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_stream_1n.md
Name: demux_stream_1n

Overview:
- Parametrised, registered 1-to-N demultiplexer with per-channel valid/ready handshake; generalises the combinational 16-bit 1:16 demux.
- Each accepted input word is steered to the output channel chosen by `s`, or to all channels when `bcast` is set.
- Each channel has a one-entry holding register, so a stalled consumer does not lose data.
- Sits between a single producer and N downstream consumers in the lab datapath.

Parameters:
- WIDTH, 16, data word width in bits.
- SEL_W, 4, select width; channel count N = 2**SEL_W (default 16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- v  input  WIDTH  input data word.
- s  input  SEL_W  destination channel index.
- bcast  input  1  1 = deliver word to every channel; `s` ignored.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- a  output  N*WIDTH  channel data, flattened; channel k occupies a[k*WIDTH +: WIDTH].
- a_valid  output  N  channel k holds a word.
- a_ready  input  N  consumer k takes the word this cycle.
- drop_cnt  output  16  count of cycles with in_valid=1 and in_ready=0 (backpressure stalls); saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - all a_valid = 0
  - all channel data registers = 0
  - drop_cnt = 0
  - in_ready follows its combinational equation from the cleared state, so it is 1 during reset.
- Channel k is free when a_valid[k]=0 or a_ready[k]=1 (drained this cycle).
- in_ready (combinational):
  - bcast=0: in_ready = free[s].
  - bcast=1: in_ready = AND of free[k] over all k.
  - Depends on s, bcast, a_valid and a_ready; never on in_valid.
- Accept occurs when in_valid && in_ready.
  - Latency is 1 cycle: the word is on channel k with a_valid[k]=1 on the clock edge after accept.
- Per-channel update at each clock edge (load_k = accept && (bcast || s==k)):
  - load_k=1: data_k <= v, a_valid[k] <= 1. This applies even if a_ready[k]=1 in the same cycle (simultaneous drain and refill gives back-to-back throughput of 1 word/cycle per channel).
  - load_k=0 and a_ready[k]=1: a_valid[k] <= 0, and data_k <= 0.
  - Otherwise: hold.
- Output data for a channel with a_valid[k]=0 is all zeros. This is the same "unselected output reads 0" rule as the combinational demux.
- a_ready[k] asserted while a_valid[k]=0 has no effect.
- Stable hold: while a_valid[k]=1 and a_ready[k]=0, data_k does not change, even when the input targets k (the input is stalled instead).
- drop_cnt increments by 1 each cycle with in_valid=1 and in_ready=0; holds at 16'hFFFF.
- Channels are independent: stalls on one channel do not block unicast traffic to another channel.
- A broadcast blocks until every channel is free simultaneously. No partial broadcast is ever delivered.
- Reset mid-transfer discards all held words; no output glitches other than the drop to 0.

Test Plan:
- Reset then unicast sweep: rst_n low 2 cycles; then v=16'h000F, in_valid=1, all a_ready=1, s=0..15 one per cycle. Required each cycle after: exactly a_valid[s_prev]=1 with a[s_prev]=16'h000F, all other channels 0, in_ready=1 throughout, drop_cnt=0.
- Stall and hold: a_ready[3]=0; send 16'hA5A5 to s=3, then 16'h1234 to s=3 for 4 cycles. Required: a[3]=16'hA5A5 held, in_ready=0, drop_cnt=4. Then a_ready[3]=1: 16'h1234 accepted that cycle and appears next cycle.
- Independence: channel 3 stalled holding a word; send 16'hBEEF to s=7. Required: in_ready=1 and a[7]=16'hBEEF after 1 cycle.
- Broadcast: all channels empty; bcast=1, v=16'hFFFF, in_valid=1 for 1 cycle. Required: next cycle all 16 a_valid=1 and every a[k]=16'hFFFF. Repeat with a_ready[9]=0 and channel 9 full: in_ready=0 and no channel is loaded until a_ready[9]=1.
- Back-to-back: a_ready[5]=1 constant; words 1,2,3 to s=5 on consecutive cycles. Required: a[5]=1,2,3 on consecutive cycles with a_valid[5]=1 continuously.
- Async reset mid-operation: drop rst_n between clock edges while channels 2 and 9 hold data. Required: a_valid=0, a=0 and drop_cnt=0 immediately, without waiting for a clock edge.
